fifo_rr_sched: RTL

FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

---
 rtl/fifo_sched_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/fifo_rr_sched.sv | 70 +++++++
 3 files changed

// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: scheduler state encoding and round-robin pointer helper
package fifo_sched_pkg;
  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} sched_state_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after last_grant
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       grant_valid
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] idx;
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    idx = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'(rr_next(int'(idx), NUM_REQ));
      if (!grant_valid && req[idx]) begin
        grant = idx;
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin FIFO-to-port scheduler; define SCHED_BURST_EN for multi-word grants
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_rdata,
  output logic [NUM_REQ-1:0]            fifo_rden,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_src
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_cfg
    $error("fifo_rr_sched: parameter out of range");
  end
  sched_state_t state, state_nx;
  logic [IW-1:0] grant, last_grant, arb_grant;
  logic arb_valid, hs, burst;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(~fifo_empty),
    .last_grant(last_grant),
    .grant(arb_grant),
    .grant_valid(arb_valid)
  );
  assign hs = (state == OUT) && out_ready;
  assign fifo_rden = (state == RD) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;
`ifdef SCHED_BURST_EN
  logic [4:0] burst_cnt;
  assign burst = !fifo_empty[grant] && (burst_cnt < 5'(BURST_LEN - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) burst_cnt <= '0;
    else if (hs) burst_cnt <= burst ? burst_cnt + 5'd1 : '0;
`else
  assign burst = 1'b0;
`endif
  always_comb
    state_nx = (state == IDLE) ? (arb_valid ? RD : IDLE) :
               (state == RD)   ? CAP :
               (state == CAP)  ? OUT :
               (out_ready ? (burst ? RD : IDLE) : OUT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && arb_valid) grant <= arb_grant;
      if (state == CAP) begin
        out_data  <= fifo_rdata[grant*DATA_WIDTH +: DATA_WIDTH];
        out_src   <= grant;
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid <= 1'b0;
        if (!burst) last_grant <= grant;
      end
    end
  end
endmodule
